pipemdu: RTL and testbench

Iterative multiply/divide unit for the pipelined CPU's EXE stage. It sits beside the ALU, takes the same forwarded operand pair and produces the HI/LO register pair. MFHI/MFLO read that pair back into the datapath. While an operation is in flight the unit raises `busy`, which the hazard logic uses to stall the ID/EXE stages.

---
 rtl/pipemdu_if.sv | 27 ++
 rtl/pipemdu.sv | 123 ++++++++++++
 tb/tb_pipemdu.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipemdu_if.sv
// Operand/result bundle between the EXE stage and the multiply/divide unit.
// The master issues operations and MTHI/MTLO writes; the slave is the unit itself.
interface pipemdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/pipemdu.sv
// Iterative multiply/divide unit: magnitude shift-add multiply or restoring divide
// over WIDTH cycles, then a sign-fix/writeback cycle into the HI/LO pair.
module pipemdu #(
  parameter int WIDTH = 32
) (
  input logic        clock,
  input logic        resetn,
  pipemdu_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_mag, b_mag, a_orig;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [CW-1:0]      cnt;
  logic               neg_pq, neg_r;

  logic               signed_in;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, trial, diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, hi_res, lo_res;

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    signed_in = ~bus.op[0];
    a_abs     = (signed_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs     = (signed_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Multiply: multiplier sits in the low half and shifts out LSB first.
    mul_sum = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_mag})
                     : {1'b0, acc[2*WIDTH-1:WIDTH]};
    // Divide: low half holds dividend bits shifting out MSB first, quotient bits shift in.
    trial = acc[2*WIDTH-1:WIDTH-1];
    diff  = trial - {1'b0, b_mag};
    q_bit = ~diff[WIDTH];

    if (op_q[1])
      acc_step = {(q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
    else
      acc_step = {mul_sum, acc[WIDTH-1:1]};
  end

  always_comb begin
    prod = neg_pq ? -acc : acc;
    quo  = neg_pq ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!op_q[1]) begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end else if (b_mag == '0) begin
      hi_res = a_orig;
      lo_res = '1;
    end else begin
      hi_res = rem;
      lo_res = quo;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      op_q     <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      a_orig   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_pq   <= 1'b0;
      neg_r    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.busy <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (bus.wr_hi) bus.hi <= bus.wdata;
          if (bus.wr_lo) bus.lo <= bus.wdata;
          if (bus.start) begin
            op_q   <= bus.op;
            a_mag  <= a_abs;
            b_mag  <= b_abs;
            a_orig <= bus.a;
            acc    <= bus.op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
            neg_pq <= signed_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= signed_in & bus.a[WIDTH-1];
            cnt    <= '0;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          bus.hi   <= hi_res;
          bus.lo   <= lo_res;
          bus.done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pipemdu.sv
// Self-checking bench for pipemdu: directed vectors, randomized ops against an
// arithmetic reference model, busy-time writes/starts, reset abort and back-to-back.
module tb_pipemdu;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  pipemdu_if #(.WIDTH(32)) bus();
  pipemdu #(.WIDTH(32)) dut (.clock(clock), .resetn(resetn), .bus(bus.slave));

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (op)
      2'd0: r = 64'(sa * sb);
      2'd1: r = {32'd0, a} * {32'd0, b};
      2'd2: if (b == 0) r = {a, 32'hFFFFFFFF};
            else begin q = sa / sb; m = sa % sb; r = {m[31:0], q[31:0]}; end
      default: if (b == 0) r = {a, 32'hFFFFFFFF};
               else r = {a % b, a / b};
    endcase
    return r;
  endfunction

  // Drives one operation from a negedge and returns what was seen at the negedge after the last busy cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output logic done_seen, output logic early_done,
                        output logic [31:0] hi_o, output logic [31:0] lo_o);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    nbusy = 0;
    early_done = 1'b0;
    while (bus.busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      if (bus.done !== 1'b0) early_done = 1'b1;
      @(negedge clock);
    end
    done_seen = bus.done;
    hi_o = bus.hi;
    lo_o = bus.lo;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd5; bus.b = 32'd6;
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'hFFFF0000;
    repeat (3) @(negedge clock);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo); end
    bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    resetn = 1'b1;
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [8] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] t_a  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'd100, 32'h80000000};
    logic [31:0] t_b  [8] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic [31:0] t_hi [8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h64, 32'h0};
    logic [31:0] t_lo [8] = '{32'h00000001, 32'hFFFFFFEB, 32'h0, 32'hFFFFFFFD, 32'd3, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'h80000000};
    int n; logic dn, early; logic [31:0] h, l;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], n, dn, early, h, l);
      checks++; if (n != 33) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected 33", i, n); end
      checks++; if (dn !== 1'b1) begin errors++; $display("FAIL dir%0d_done: got %b expected 1", i, dn); end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL dir%0d_early_done: got %b expected 0", i, early); end
      checks++; if (h !== t_hi[i]) begin errors++; $display("FAIL dir%0d_hi: got %h expected %h", i, h, t_hi[i]); end
      checks++; if (l !== t_lo[i]) begin errors++; $display("FAIL dir%0d_lo: got %h expected %h", i, l, t_lo[i]); end
      @(negedge clock);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, bus.done); end
      checks++; if (bus.hi !== t_hi[i] || bus.lo !== t_lo[i]) begin
        errors++; $display("FAIL dir%0d_hold: got %h_%h expected %h_%h", i, bus.hi, bus.lo, t_hi[i], t_lo[i]);
      end
      exp_hi = t_hi[i]; exp_lo = t_lo[i];
    end
  endtask

  task automatic test_random();
    int n; logic dn, early; logic [31:0] h, l, ra, rb; logic [1:0] rop; logic [63:0] r;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.wr_hi = 1'($urandom_range(0, 1)); bus.wr_lo = 1'($urandom_range(0, 1)); bus.wdata = $urandom;
        if (bus.wr_hi) exp_hi = bus.wdata;
        if (bus.wr_lo) exp_lo = bus.wdata;
        @(negedge clock);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
          errors++; $display("FAIL rnd%0d_mt: got %h_%h expected %h_%h", i, bus.hi, bus.lo, exp_hi, exp_lo);
        end
      end
      rop = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 6))
        0: rb = 32'h0;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = 32'($urandom_range(1, 17));
        default: ;
      endcase
      r = ref_model(rop, ra, rb);
      run_op(rop, ra, rb, n, dn, early, h, l);
      checks++; if (n != 33 || dn !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_timing: got busy=%0d done=%b expected busy=33 done=1", i, n, dn);
      end
      checks++; if ({h, l} !== r) begin
        errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, rop, ra, rb, h, l, r[63:32], r[31:0]);
      end
      exp_hi = r[63:32]; exp_lo = r[31:0];
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    bus.wr_hi = 1'b1; bus.wdata = 32'hCAFEF00D;
    @(negedge clock);
    bus.wr_hi = 1'b0;
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      if (k == 10) begin bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd9; bus.b = 32'd9; end
      if (k == 11) bus.start = 1'b0;
      if (k == 12) begin bus.wr_hi = 1'b1; bus.wdata = 32'h1234; end
      if (k == 13) begin
        bus.wr_hi = 1'b0;
        checks++; if (bus.hi !== 32'hCAFEF00D) begin errors++; $display("FAIL busy_write_dropped: got %h expected cafef00d", bus.hi); end
      end
      @(negedge clock);
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b expected 1", bus.done); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'd15) begin
      errors++; $display("FAIL ign_result: got %h_%h expected 00000000_0000000f", bus.hi, bus.lo);
    end
    n = 0;
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_start_dropped: got busy=%b expected 0", bus.busy); end
    exp_hi = 32'h0; exp_lo = 32'd15;
  endtask

  task automatic test_reset_abort();
    int n;
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h55556666;
    @(negedge clock);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++; $display("FAIL abort_regs: got %h_%h expected 0_0", bus.hi, bus.lo);
    end
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b expected 0", bus.busy); end
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'hA5A5A5A5;
    @(negedge clock);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    checks++; if (bus.hi !== 32'hA5A5A5A5 || bus.lo !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL mt_both: got %h_%h expected a5a5a5a5_a5a5a5a5", bus.hi, bus.lo);
    end
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h13579BDF;
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd2; bus.b = 32'd3;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    checks++; if (bus.hi !== 32'h13579BDF || bus.lo !== 32'h13579BDF || bus.busy !== 1'b1) begin
      errors++; $display("FAIL write_start: got %h_%h busy=%b expected 13579bdf_13579bdf busy=1", bus.hi, bus.lo, bus.busy);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin n++; @(negedge clock); end
    checks++; if (n != 33) begin errors++; $display("FAIL write_start_cycles: got %0d expected 33", n); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'd6 || bus.done !== 1'b1) begin
      errors++; $display("FAIL write_start_result: got %h_%h done=%b expected 00000000_00000006 done=1", bus.hi, bus.lo, bus.done);
    end
    exp_hi = 32'h0; exp_lo = 32'd6;
  endtask

  task automatic test_back_to_back();
    int n; logic dn, early; logic [31:0] h, l, ra, rb; logic [1:0] rop; logic [63:0] r;
    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom_range(0, 3)); ra = $urandom; rb = $urandom;
      r = ref_model(rop, ra, rb);
      run_op(rop, ra, rb, n, dn, early, h, l);
      checks++; if (n != 33 || dn !== 1'b1 || early !== 1'b0) begin
        errors++; $display("FAIL b2b%0d_timing: got busy=%0d done=%b early=%b expected 33 1 0", i, n, dn, early);
      end
      checks++; if ({h, l} !== r) begin
        errors++; $display("FAIL b2b%0d_result: got %h_%h expected %h_%h", i, h, l, r[63:32], r[31:0]);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
